eq_band_mixer: RTL and testbench

EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

---
 rtl/eq_band_mixer.sv | 120 ++++++++++++
 tb/tb_eq_band_mixer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// Multi-band equaliser mixer: one signed gain per band, one shared multiplier
// that sums one band per cycle, then a rounded and saturated 24-bit output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for sample_valid while enable is high
// MAC   | accumulating snap[idx]*gain[idx], one band per clock
// OUT   | round, clamp, register audio_out, pulse out_valid
module eq_band_mixer #(
  parameter int NUM_BANDS = 10,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    sample_valid,
  input  logic [NUM_BANDS*24-1:0] band_in,
  input  logic                    gain_we,
  input  logic [7:0]              gain_addr,
  input  logic [GAIN_W-1:0]       gain_data,
  output logic [23:0]             audio_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    sat,
  output logic                    overrun
);

  localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int PROD_W = 24 + GAIN_W;
  localparam logic signed [47:0] RND  = 48'sd1 <<< (GAIN_FRAC - 1);
  localparam logic signed [47:0] MAXV = 48'sd8388607;
  localparam logic signed [47:0] MINV = -48'sd8388608;
  localparam logic [GAIN_W-1:0]  UNITY = GAIN_W'(2 ** GAIN_FRAC);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nx;

  logic        [IDX_W-1:0]  idx;
  logic signed [23:0]       snap [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain [NUM_BANDS];
  logic signed [47:0]       acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [47:0]       rnd;
  logic                     start, last, clamp_hi, clamp_lo;

  assign start = enable && sample_valid;
  assign last  = (idx == IDX_W'(NUM_BANDS - 1));

  // Operands widened first so the product keeps full precision.
  assign prod     = PROD_W'(snap[idx]) * PROD_W'(gain[idx]);
  assign rnd      = (acc + RND) >>> GAIN_FRAC;
  assign clamp_hi = (rnd > MAXV);
  assign clamp_lo = (rnd < MINV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (last)  state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      acc       <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) begin
        snap[k] <= '0;
        gain[k] <= UNITY;
      end
    end else begin
      out_valid <= 1'b0;
      sat       <= 1'b0;
      overrun   <= sample_valid && (state != IDLE);

      // Out-of-range addresses simply match no band.
      for (int k = 0; k < NUM_BANDS; k++)
        if (gain_we && gain_addr == 8'(k)) gain[k] <= gain_data;

      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_BANDS; k++)
              snap[k] <= band_in[24*k +: 24];
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + 48'(prod);
          idx <= last ? '0 : idx + IDX_W'(1);
        end
        OUT: begin
          audio_out <= clamp_hi ? 24'h7FFFFF :
                       clamp_lo ? 24'h800000 : rnd[23:0];
          out_valid <= 1'b1;
          sat       <= clamp_hi || clamp_lo;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed bench for eq_band_mixer with four bands: a vector table for the
// arithmetic, plus hand sequences for latency, overrun, gain timing and reset.
module tb_eq_band_mixer;

  localparam int NB = 4;

  logic          clk, rst_n, enable, sample_valid, gain_we;
  logic [NB*24-1:0] band_in;
  logic [7:0]    gain_addr;
  logic [15:0]   gain_data;
  logic [23:0]   audio_out;
  logic          out_valid, busy, sat, overrun;

  int n_cmp = 0;
  int n_fail = 0;

  eq_band_mixer #(.NUM_BANDS(NB), .GAIN_W(16), .GAIN_FRAC(14)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .band_in(band_in), .gain_we(gain_we), .gain_addr(gain_addr),
    .gain_data(gain_data), .audio_out(audio_out), .out_valid(out_valid),
    .busy(busy), .sat(sat), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [95:0] bands;     // {b3,b2,b1,b0}
    logic [63:0] gains;     // {g3,g2,g1,g0}
    logic [23:0] exp_out;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [95:0] b,
                              input logic [63:0] g, input logic [23:0] e,
                              input logic s);
    vec_t v;
    v.name = n; v.bands = b; v.gains = g; v.exp_out = e; v.exp_sat = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_gains(input logic [63:0] g);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      gain_we = 1'b1; gain_addr = 8'(k); gain_data = g[16*k +: 16];
    end
    @(negedge clk);
    gain_we = 1'b0;
  endtask

  // Returns at the negedge just after the accepting edge E0.
  task automatic strobe(input logic [95:0] b);
    @(negedge clk);
    band_in = b; enable = 1'b1; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    band_in = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: no out_valid within 20 cycles", name);
    end
  endtask

  int          lat, nv;
  logic [23:0] got;
  localparam logic [63:0] UNITY4 = {4{16'h4000}};

  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; gain_we = 1'b0;
    gain_addr = '0; gain_data = '0; band_in = '0;

    vecs.push_back(mk("basic", {24'sd0, -24'sd500, 24'sd2000, 24'sd1000}, UNITY4, 24'd2500, 1'b0));
    vecs.push_back(mk("half_4000", {24'sd0, 24'sd0, 24'sd4000, 24'sd0}, 64'h0000_0000_2000_0000, 24'd2000, 1'b0));
    vecs.push_back(mk("half_3", {24'sd0, 24'sd0, 24'sd3, 24'sd0}, 64'h0000_0000_2000_0000, 24'd2, 1'b0));
    vecs.push_back(mk("half_m3", {24'sd0, 24'sd0, -24'sd3, 24'sd0}, 64'h0000_0000_2000_0000, 24'hFFFFFF, 1'b0));
    vecs.push_back(mk("pos_sat", {4{24'h7FFFFF}}, UNITY4, 24'h7FFFFF, 1'b1));
    vecs.push_back(mk("neg_sat", {4{24'h800000}}, UNITY4, 24'h800000, 1'b1));
    vecs.push_back(mk("pos_edge", {24'h0, 24'h0, 24'h0, 24'h7FFFFF}, UNITY4, 24'h7FFFFF, 1'b0));
    vecs.push_back(mk("neg_edge", {24'h0, 24'h0, 24'h0, 24'h800000}, UNITY4, 24'h800000, 1'b0));
    vecs.push_back(mk("mixed", {24'sd800, 24'sd400, 24'sd50, 24'sd100}, 64'h1000_2000_C000_4000, 24'd450, 1'b0));
    vecs.push_back(mk("half_up", {24'sd0, 24'sd0, 24'sd0, 24'sd8192}, 64'h0000_0000_0000_0001, 24'd1, 1'b0));
    vecs.push_back(mk("neg_half", {24'sd0, 24'sd0, 24'sd0, -24'sd8192}, 64'h0000_0000_0000_0001, 24'd0, 1'b0));

    #12;
    check("rst audio_out", 32'(audio_out), 32'd0);
    check("rst flags", {27'd0, out_valid, busy, sat, overrun, 1'b0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency and busy window with the power-on unity gains.
    strobe({24'sd0, -24'sd500, 24'sd2000, 24'sd1000});
    check("lat busy E0", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("lat busy/ov E%0d", i), {30'd0, busy, out_valid}, 32'b10);
    end
    @(negedge clk);
    check("lat E5 ov/busy/sat", {29'd0, out_valid, busy, sat}, 32'b100);
    check("lat E5 audio", 32'(audio_out), 32'd2500);
    @(negedge clk);
    check("lat E6 ov", {31'd0, out_valid}, 32'd0);
    check("lat E6 hold", 32'(audio_out), 32'd2500);

    foreach (vecs[i]) begin
      set_gains(vecs[i].gains);
      strobe(vecs[i].bands);
      wait_out(vecs[i].name, lat);
      check({vecs[i].name, " lat"}, 32'(lat), 32'd5);
      check({vecs[i].name, " out"}, 32'(audio_out), 32'(vecs[i].exp_out));
      check({vecs[i].name, " sat"}, {31'd0, sat}, {31'd0, vecs[i].exp_sat});
      @(negedge clk);
      check({vecs[i].name, " pulse"}, {30'd0, out_valid, sat}, 32'd0);
    end

    // Strobe with enable low in IDLE is ignored.
    @(negedge clk);
    enable = 1'b0; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("dis busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("dis overrun", {30'd0, overrun, busy}, 32'd0);

    // Overrun: second strobe lands on E2.
    set_gains(UNITY4);
    strobe({24'sd0, -24'sd500, 24'sd2000, 24'sd1000});
    @(negedge clk);
    band_in = {4{24'sd77}}; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("ovr pulse", {31'd0, overrun}, 32'd1);
    nv = 0; got = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) check("ovr one cycle", {31'd0, overrun}, 32'd0);
      if (out_valid) begin nv++; got = audio_out; end
    end
    check("ovr n out_valid", 32'(nv), 32'd1);
    check("ovr result", 32'(got), 32'd2500);

    // enable dropped mid-MAC: sample still completes.
    strobe({24'sd0, -24'sd500, 24'sd2000, 24'sd1000});
    enable = 1'b0;
    wait_out("en_drop", lat);
    check("en_drop out", 32'(audio_out), 32'd2500);
    enable = 1'b1;

    // Gain write to band 3 sampled at E1 is seen by the band-3 MAC at E4.
    strobe({24'sd1000, 24'sd0, 24'sd0, 24'sd0});
    gain_we = 1'b1; gain_addr = 8'd3; gain_data = 16'h2000;
    @(negedge clk);
    gain_we = 1'b0;
    wait_out("gw_mid", lat);
    check("gw_mid out", 32'(audio_out), 32'd500);

    // Out-of-range address changes nothing.
    @(negedge clk);
    gain_we = 1'b1; gain_addr = 8'd7; gain_data = 16'h0000;
    @(negedge clk);
    gain_we = 1'b0;
    strobe({24'sd400, 24'sd300, 24'sd200, 24'sd100});
    wait_out("gw_oob", lat);
    check("gw_oob out", 32'(audio_out), 32'd800);

    // Reset at E2 aborts the sample and restores unity gains.
    set_gains(64'h0000_2000_2000_2000);
    strobe({24'sd0, -24'sd500, 24'sd2000, 24'sd1000});
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid audio", 32'(audio_out), 32'd0);
    check("rst mid flags", {28'd0, out_valid, busy, sat, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("rst no out_valid", 32'(nv), 32'd0);
    strobe({24'sd0, -24'sd500, 24'sd2000, 24'sd1000});
    wait_out("rst_unity", lat);
    check("rst unity out", 32'(audio_out), 32'd2500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
